// File: rtl/pwm_audio_demod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_audio_demod_pkg
// Description : Shared constants and helpers for the PWM audio demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_audio_demod_pkg;

    localparam int c_PERIOD_FULL_FPS  = 100;
    localparam int c_PERIOD_HALF_RATE = 50;

    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_ACC        = 2'd1;
    localparam logic [1:0] c_ST_WAIT_START = 2'd2;

    // Width able to hold every value 0..period inclusive.
    function automatic int cnt_bits(input int period);
        return $clog2(period + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_demod_outbuf.sv
`default_nettype none
// ============================================================================
// Module      : pwm_demod_outbuf
// Description : Single-entry valid/ready holding register with drop detect.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_demod_outbuf #(
    parameter int DATA_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [DATA_BITS-1:0] i_sample,
    input  logic                 i_phase,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_sample,
    output logic                 o_phase,
    output logic                 o_drop
);

    logic                 r_valid;
    logic [DATA_BITS-1:0] r_sample;
    logic                 r_phase;
    logic                 w_accept;

    // A load is taken when the slot is empty or is being drained this cycle.
    assign w_accept = i_load & (~r_valid | i_ready);
    assign o_drop   = i_load & r_valid & ~i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_phase  <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_sample <= i_sample;
            r_phase  <= i_phase;
        end else if (i_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_sample = r_sample;
    assign o_phase  = r_phase;

endmodule
`default_nettype wire

// File: rtl/pwm_audio_demod.sv
`default_nettype none
// ============================================================================
// Module      : pwm_audio_demod
// Description : Recovers one unsigned sample per PWM period from the 1-bit
//               audio stream by counting de-inverted ones.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_audio_demod
    import pwm_audio_demod_pkg::*;
#(
    parameter int PERIOD   = c_PERIOD_FULL_FPS,
    parameter int CNT_BITS = cnt_bits(PERIOD)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                period_start,
    input  logic                invert,
    input  logic                audio_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [CNT_BITS-1:0] out_sample,
    output logic                out_phase,
    output logic                period_err,
    output logic                overrun,
    input  logic                clear_err
);

    localparam logic [CNT_BITS-1:0] c_LAST_BIT = CNT_BITS'(PERIOD - 1);
    localparam logic [CNT_BITS-1:0] c_ONE      = CNT_BITS'(1);

    logic [1:0]          r_state;
    logic [CNT_BITS-1:0] r_bits;
    logic [CNT_BITS-1:0] r_count;
    logic                r_invert;
    logic                r_period_err;
    logic                r_overrun;

    logic                w_bit;
    logic                w_first_bit;
    logic                w_start;
    logic                w_step;
    logic                w_complete;
    logic                w_frame_err;
    logic                w_drop;
    logic [CNT_BITS-1:0] w_sum;

    assign w_bit       = audio_in ^ r_invert;
    assign w_first_bit = audio_in ^ invert;
    assign w_start     = tick & period_start;
    assign w_step      = tick & ~period_start;
    assign w_sum       = r_count + (w_bit ? c_ONE : '0);
    assign w_complete  = w_step & (r_state == c_ST_ACC) & (r_bits == c_LAST_BIT);
    // A period_start mid-accumulation or a missing one after a full period.
    assign w_frame_err = (w_start & (r_state == c_ST_ACC)) |
                         (w_step  & (r_state == c_ST_WAIT_START));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_bits   <= '0;
            r_count  <= '0;
            r_invert <= 1'b0;
        end else if (w_start) begin
            r_state  <= c_ST_ACC;
            r_invert <= invert;
            r_bits   <= c_ONE;
            r_count  <= w_first_bit ? c_ONE : '0;
        end else if (w_step) begin
            case (r_state)
                c_ST_ACC: begin
                    r_bits  <= r_bits + c_ONE;
                    r_count <= w_sum;
                    if (r_bits == c_LAST_BIT) begin
                        r_state <= c_ST_WAIT_START;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_period_err <= w_frame_err | (r_period_err & ~clear_err);
            r_overrun    <= w_drop      | (r_overrun    & ~clear_err);
        end
    end

    pwm_demod_outbuf #(
        .DATA_BITS (CNT_BITS)
    ) u_outbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_complete),
        .i_sample (w_sum),
        .i_phase  (r_invert),
        .i_ready  (out_ready),
        .o_valid  (out_valid),
        .o_sample (out_sample),
        .o_phase  (out_phase),
        .o_drop   (w_drop)
    );

    assign period_err = r_period_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_demod.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_audio_demod
// Description : Scoreboard bench for pwm_audio_demod against a per-period
//               arithmetic model (recovered value = min(sample, PERIOD)).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_audio_demod;

    localparam int PERIOD   = 100;
    localparam int CNT_BITS = $clog2(PERIOD + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic period_start = 1'b0;
    logic invert = 1'b0;
    logic audio_in = 1'b0;
    logic out_ready = 1'b0;
    logic clear_err = 1'b0;
    logic out_valid;
    logic [CNT_BITS-1:0] out_sample;
    logic out_phase;
    logic period_err;
    logic overrun;

    typedef struct {
        int s;
        bit ph;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rdy_mode = 1;

    pwm_audio_demod #(
        .PERIOD   (PERIOD),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .period_start (period_start),
        .invert       (invert),
        .audio_in     (audio_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_sample   (out_sample),
        .out_phase    (out_phase),
        .period_err   (period_err),
        .overrun      (overrun),
        .clear_err    (clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom % 2);
        endcase
    end

    // Monitor: every accepted transfer is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_transfer", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sample", int'(out_sample), e.s);
                chk("phase", int'(out_phase), int'(e.ph));
            end
        end
    end

    // Drives nbits ticks of a period carrying sample s; line bit c is (s > c) ^ inv.
    task automatic run_period(input int s, input bit inv, input int nbits,
                              input bit gaps, input bit push, input bit lat);
        for (int c = 0; c < nbits; c++) begin
            if (gaps) begin
                int idle_n;
                idle_n = $urandom_range(0, 2);
                for (int g = 0; g < idle_n; g++) begin
                    tick         = 1'b0;
                    period_start = 1'($urandom % 2);
                    audio_in     = 1'($urandom % 2);
                    step();
                end
            end
            tick         = 1'b1;
            period_start = (c == 0);
            invert       = (c == 0) ? inv : 1'($urandom % 2);
            audio_in     = ((s > c) ? 1'b1 : 1'b0) ^ inv;
            if (lat && c == nbits - 1) begin
                @(negedge clk);
                chk("latency_pre", int'(out_valid), 0);
            end
            step();
        end
        tick         = 1'b0;
        period_start = 1'b0;
        if (push) sb.push_back('{s: (s > PERIOD) ? PERIOD : s, ph: inv});
        if (lat) begin
            @(negedge clk);
            chk("latency_post", int'(out_valid), 1);
        end
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sample", int'(out_sample), 0);
        chk("rst_phase", int'(out_phase), 0);
        chk("rst_perr", int'(period_err), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Plain periods, then alternating inversion
        rdy_mode = 1;
        repeat (3) run_period(37, 1'b0, PERIOD, 1'b0, 1'b1, 1'b1);
        run_period(37, 1'b1, PERIOD, 1'b0, 1'b1, 1'b1);
        run_period(37, 1'b0, PERIOD, 1'b0, 1'b1, 1'b1);
        run_period(37, 1'b1, PERIOD, 1'b0, 1'b1, 1'b1);
        chk("plain_perr", int'(period_err), 0);
        chk("plain_ovr", int'(overrun), 0);

        // Saturation and all-ones line carrying zero
        run_period(127, 1'b0, PERIOD, 1'b0, 1'b1, 1'b1);
        run_period(0, 1'b1, PERIOD, 1'b0, 1'b1, 1'b1);
        run_period(100, 1'b1, PERIOD, 1'b0, 1'b1, 1'b1);

        // Short period aborted by an early period_start
        run_period(37, 1'b0, 50, 1'b0, 1'b0, 1'b0);
        run_period(45, 1'b1, PERIOD, 1'b0, 1'b1, 1'b1);
        chk("short_perr", int'(period_err), 1);
        pulse_clear();
        chk("short_clear", int'(period_err), 0);

        // Missing period_start after a full period, coincident with clear
        run_period(60, 1'b0, PERIOD, 1'b0, 1'b1, 1'b1);
        tick = 1'b1; period_start = 1'b0; audio_in = 1'b1; clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("missing_perr_set_wins", int'(period_err), 1);
        repeat (5) step();
        tick = 1'b0;
        step();
        chk("idle_ignores_valid", int'(out_valid), 0);
        pulse_clear();
        chk("idle_ignores_perr", int'(period_err), 0);
        run_period(80, 1'b1, PERIOD, 1'b0, 1'b1, 1'b1);
        chk("resync_perr", int'(period_err), 0);

        // Overrun with out_ready held low across two completions
        rdy_mode = 0;
        repeat (2) step();
        run_period(10, 1'b0, PERIOD, 1'b0, 1'b1, 1'b1);
        run_period(20, 1'b1, PERIOD, 1'b0, 1'b0, 1'b0);
        step();
        chk("ovr_valid", int'(out_valid), 1);
        chk("ovr_sample", int'(out_sample), 10);
        chk("ovr_phase", int'(out_phase), 0);
        chk("ovr_flag", int'(overrun), 1);
        rdy_mode = 1;
        repeat (3) step();
        chk("ovr_drained", int'(out_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        pulse_clear();
        chk("ovr_clear", int'(overrun), 0);

        // Reset in the middle of a period
        run_period(30, 1'b0, 20, 1'b0, 1'b0, 1'b0);
        run_period(55, 1'b0, 40, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_perr", int'(period_err), 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_sample", int'(out_sample), 0);
        chk("mid_rst_perr", int'(period_err), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 40; c < PERIOD; c++) begin
            tick = 1'b1; period_start = 1'b0; audio_in = (55 > c);
            step();
        end
        tick = 1'b0;
        step();
        chk("post_rst_valid", int'(out_valid), 0);
        chk("post_rst_perr", int'(period_err), 0);
        run_period(55, 1'b0, PERIOD, 1'b0, 1'b1, 1'b1);

        // Randomized periods with tick gaps and random back-pressure
        rdy_mode = 2;
        for (int k = 0; k < 20; k++) begin
            run_period($urandom_range(0, 130), 1'($urandom % 2), PERIOD, 1'b1, 1'b1, 1'b0);
        end

        rdy_mode = 1;
        for (int w = 0; w < 500 && sb.size() != 0; w++) step();
        chk("drain_timeout", sb.size(), 0);
        step();
        chk("final_perr", int'(period_err), 0);
        chk("final_ovr", int'(overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
